// File: rtl/fwvexrisc_wb_sram_target.sv
// Wishbone classic SRAM target: registered ack, WAIT_STATES wait cycles, byte-lane writes.
// Define FWVEXRISC_WB_TARGET_ERR_EN to terminate out-of-range accesses with t_err instead of aliasing.
module fwvexrisc_wb_sram_target #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] t_adr,
  input  logic [31:0] t_dat_w,
  output logic [31:0] t_dat_r,
  input  logic        t_cyc,
  input  logic        t_stb,
  input  logic [3:0]  t_sel,
  input  logic        t_we,
  output logic        t_ack,
  output logic        t_err
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          we_q, we_d;
  logic          oor_q, oor_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          ack_q, err_q;
  logic [31:0]   rdat_q;
  logic [31:0]   mem_q [DEPTH];

  logic          req_s;
  logic          enter_resp_s;
  logic [31:0]   off_s;
  logic [AW-1:0] live_idx_s;
  logic          live_oor_s;
  logic          unused_s;

  assign req_s      = t_cyc & t_stb;
  assign off_s      = t_adr - ADDR_BASE;
  assign live_idx_s = off_s[AW+1:2];
  assign unused_s   = ^{off_s[31:AW+2], off_s[1:0]};

`ifdef FWVEXRISC_WB_TARGET_ERR_EN
  localparam logic [32:0] BASE_X = {1'b0, ADDR_BASE};
  localparam logic [32:0] END_X  = BASE_X + 33'(4 * DEPTH);
  // 33-bit compare so a window ending at 2^32 does not wrap.
  assign live_oor_s = ({1'b0, t_adr} < BASE_X) || ({1'b0, t_adr} >= END_X);
`else
  assign live_oor_s = 1'b0;
`endif

  assign t_dat_r = rdat_q;
  assign t_ack   = ack_q;
  assign t_err   = err_q;

  // Next-state logic; the _d request fields are the access that commits on entering RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    we_d         = we_q;
    oor_d        = oor_q;
    sel_d        = sel_q;
    wdat_d       = wdat_q;
    enter_resp_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          idx_d  = live_idx_s;
          we_d   = t_we;
          oor_d  = live_oor_s;
          sel_d  = t_sel;
          wdat_d = t_dat_w;
          cnt_d  = 4'd0;
          if (WAIT_STATES == 0) begin
            state_d      = S_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!req_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == WS_LAST) begin
          state_d      = S_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, registered responses and read data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      sel_q   <= 4'd0;
      wdat_q  <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      ack_q   <= enter_resp_s & ~oor_d;
      err_q   <= enter_resp_s & oor_d;
      if (enter_resp_s && !we_d && !oor_d) begin
        rdat_q <= mem_q[idx_d];
      end
    end
  end

  // SRAM array is never cleared; reset only suppresses a pending write.
  always_ff @(posedge clock) begin
    if (reset && enter_resp_s && we_d && !oor_d) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_d[b]) begin
          mem_q[idx_d][8*b +: 8] <= wdat_d[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_fwvexrisc_wb_sram_target.sv
// Randomized bench for fwvexrisc_wb_sram_target: two instances (0 and 3 wait states) vs a word-array model.
module tb_fwvexrisc_wb_sram_target;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          NI    = 2;
`ifdef FWVEXRISC_WB_TARGET_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] adr   [NI];
  logic [31:0] dat_w [NI];
  logic [31:0] dat_r [NI];
  logic        cyc   [NI];
  logic        stb   [NI];
  logic        we    [NI];
  logic        ack   [NI];
  logic        err   [NI];
  logic [3:0]  sel   [NI];
  int          ws_of [NI] = '{0, 3};

  logic [31:0] mem_m   [NI][DEPTH];
  logic [31:0] last_rd [NI];
  int          err_cnt = 0;
  int          chk_cnt = 0;

  fwvexrisc_wb_sram_target #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(reset), .t_adr(adr[0]), .t_dat_w(dat_w[0]), .t_dat_r(dat_r[0]),
    .t_cyc(cyc[0]), .t_stb(stb[0]), .t_sel(sel[0]), .t_we(we[0]), .t_ack(ack[0]), .t_err(err[0]));

  fwvexrisc_wb_sram_target #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .WAIT_STATES(3)) u_ws3 (
    .clock(clock), .reset(reset), .t_adr(adr[1]), .t_dat_w(dat_w[1]), .t_dat_r(dat_r[1]),
    .t_cyc(cyc[1]), .t_stb(stb[1]), .t_sel(sel[1]), .t_we(we[1]), .t_ack(ack[1]), .t_err(err[1]));

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + 33'(4 * DEPTH)));
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) % DEPTH);
  endfunction

  // One complete classic cycle; strobe retires in the ack cycle.
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag);
    int n;
    bit seen;
    bit oor;
    int ix;
    oor = ERR_EN && !in_range(a);
    ix  = idx_of(a);
    adr[k] = a; dat_w[k] = d; sel[k] = s; we[k] = w; cyc[k] = 1'b1; stb[k] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (ack[k] || err[k]) seen = 1'b1;
    end
    check_eq({tag, ".lat"}, 32'(n), 32'(1 + ws_of[k]));
    check_eq({tag, ".ack"}, 32'(ack[k]), 32'(!oor));
    check_eq({tag, ".err"}, 32'(err[k]), 32'(oor));
    if (!oor) begin
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mem_m[k][ix][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        last_rd[k] = mem_m[k][ix];
      end
    end
    check_eq({tag, ".dat"}, dat_r[k], last_rd[k]);
    @(posedge clock); #1;
    cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    check_eq({tag, ".retire1"}, {30'd0, ack[k], err[k]}, 32'd0);
    @(posedge clock); #1;
    check_eq({tag, ".retire2"}, {30'd0, ack[k], err[k]}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    for (int k = 0; k < NI; k++) begin
      adr[k] = BASE; dat_w[k] = 32'h0; sel[k] = 4'h0; we[k] = 1'b0;
      cyc[k] = 1'b1; stb[k] = 1'b1;
    end
    // Reset held with a live request.
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      for (int k = 0; k < NI; k++) begin
        check_eq("rst.ack", 32'(ack[k]), 32'd0);
        check_eq("rst.err", 32'(err[k]), 32'd0);
        check_eq("rst.dat", dat_r[k], 32'h0);
      end
    end
    for (int k = 0; k < NI; k++) begin
      cyc[k] = 1'b0; stb[k] = 1'b0; last_rd[k] = 32'h0;
    end
    reset = 1'b1;

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < DEPTH; i++)
        xfer(k, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, "fill");

    xfer(0, 1'b1, BASE + 32'd8, 32'hDEADBEEF, 4'hF, "dir.w");
    xfer(0, 1'b0, BASE + 32'd8, 32'h0, 4'h0, "dir.r");
    check_eq("dir.beef", dat_r[0], 32'hDEADBEEF);
    xfer(0, 1'b1, BASE + 32'd8, 32'h11223344, 4'b0100, "lane.w");
    xfer(0, 1'b0, BASE + 32'd8, 32'h0, 4'h0, "lane.r");
    check_eq("lane.val", dat_r[0], 32'hDE22BEEF);
    xfer(0, 1'b1, BASE + 32'd8, 32'h55555555, 4'h0, "sel0.w");
    xfer(0, 1'b0, BASE + 32'd8, 32'h0, 4'hF, "sel0.r");
    check_eq("sel0.val", dat_r[0], 32'hDE22BEEF);
    xfer(1, 1'b0, BASE + 32'd8, 32'h0, 4'h0, "ws3.r");

    // Abort a wait-stated write by dropping stb.
    adr[1] = BASE + 32'd12; dat_w[1] = ~mem_m[1][3]; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    stb[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      check_eq("abort.ack", 32'(ack[1]), 32'd0);
    end
    cyc[1] = 1'b0; we[1] = 1'b0;
    xfer(1, 1'b0, BASE + 32'd12, 32'h0, 4'h0, "abort.r");

    // Reset in the middle of a wait-stated write.
    adr[1] = BASE + 32'd20; dat_w[1] = ~mem_m[1][5]; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check_eq("mrst.ack", 32'(ack[1]), 32'd0);
    check_eq("mrst.dat1", dat_r[1], 32'h0);
    check_eq("mrst.dat0", dat_r[0], 32'h0);
    reset = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      check_eq("mrst.idle", 32'(ack[1]), 32'd0);
    end
    xfer(1, 1'b0, BASE + 32'd20, 32'h0, 4'h0, "mrst.r");

    // One past the top of the window: error or alias onto word 0.
    for (int k = 0; k < NI; k++) begin
      xfer(k, 1'b1, BASE + 32'(4 * DEPTH), 32'hA5A5A5A5, 4'hF, "edge.w");
      xfer(k, 1'b0, BASE, 32'h0, 4'h0, "edge.r0");
      xfer(k, 1'b0, BASE + 32'(4 * DEPTH - 4), 32'h0, 4'h0, "edge.rtop");
      xfer(k, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, "edge.rout");
    end

    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
        else a = BASE - 32'(4 * $urandom_range(1, 8));
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      end
      d = $urandom;
      xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, d, 4'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
